rs232_rx_framed: RTL and testbench
==================================

# rs232_rx_framed

Parametrised RS232 receiver that succeeds the fixed 8N1 `rs232_to_push` block. It adds a configurable data width, optional parity, 1 or 2 stop bits, and 16x oversampling with 3-sample majority voting. It also rejects false start bits and reports parity, framing and break conditions. It sits between the RXD/RTSn board pins and a push-handshake FIFO with an almost-full signal.

## Interface
- `CLOCK_FREQ`, real, 133000000: clock frequency in Hz.
- `BAUD_RATE`, real, 115200: line bit rate.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clock`  in  1  single system clock; every flop is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rxd_pin`  in  1  asynchronous serial input, idles high.
- `rtsn_pin`  out  1  equals `oafull` combinationally; high tells the sender to stop.
- `odata`  out  DATA_BITS  received word, LSB first on the wire.
- `operr`  out  1  parity error, qualified by `oenable`.
- `oferr`  out  1  framing error (a stop bit sampled low), qualified by `oenable`.
- `obreak`  out  1  break detected, qualified by `oenable`.
- `oenable`  out  1  one-clock push strobe.
- `oafull`  in  1  downstream almost full.

## Operation
- **Input synchroniser:** two flops, reset to 1. The synchronised value `rxd` feeds all logic.
- **Oversample divider:**
  - `OS_DIV = round(CLOCK_FREQ / (16*BAUD_RATE))`; elaboration fails if `OS_DIV < 2`.
  - The divider emits `os_tick` for one clock every `OS_DIV` clocks.
  - It restarts synchronously when leaving IDLE, so the first `os_tick` comes `OS_DIV` clocks after detection.
- **Sample counter:** 4 bits, counts `os_tick`s within a bit and wraps 15 -> 0.
  - Samples are taken at counts 7, 8 and 9.
  - The bit value is the majority of those three, decided at count 9.
- **States (shared enum):**
  - IDLE: `rxd == 0` -> START, with counters cleared.
  - START: majority 1 at count 9 (glitch) -> IDLE with no output. Majority 0 -> DATA.
  - DATA: shift the voted bit into the MSB of a DATA_BITS shift register, so `odata` is LSB-first aligned. After DATA_BITS bits -> PARITY if `PARITY != 0`, else STOP.
  - PARITY: compare the voted bit with the expected value. Odd: XOR of data and parity bit equals 1. Even: it equals 0. Mismatch sets `perr`. Then -> STOP.
  - STOP: one voted bit per stop bit; any stop bit 0 sets `ferr`. After the last stop decision, issue the output strobe. Then:
    - break condition -> BREAK_WAIT;
    - otherwise -> IDLE.
  - BREAK_WAIT: stay until `rxd == 1`, then -> IDLE. No further output.
- **Break condition:** all data bits 0, parity bit 0 if present, and the first stop bit 0.
- **Output registers:**
  - `odata`, `operr`, `oferr` and `obreak` update together with `oenable` and hold until the next frame.
  - With 2 stop bits, `oferr` is set if either stop bit is 0.
- **Back-pressure:** `oafull` only drives `rtsn_pin`. The receiver never drops or stalls a frame; the downstream FIFO absorbs in-flight bytes.

## Timing
- **Reset values:** `odata=0`, `operr=0`, `oferr=0`, `obreak=0`, `oenable=0`, state IDLE, synchroniser 11.
- **Reset mid-frame:** the partial frame is discarded with no strobe. The receiver is ready in IDLE on the first cycle after `reset` deasserts.
- **Start detection:** 2 clocks (synchroniser) after the pin falls, plus 1 clock to enter START.
- **Start validation:** at `os_tick` count 9, i.e. 10 `os_tick`s after START entry.
- **Bit period:** 16 `os_tick`s (`16*OS_DIV` clocks).
- **Frame latency:** `oenable` is high for exactly one clock, the clock after the `os_tick` that decides the last stop bit.
- **Next frame:** a falling edge on the clock after returning to IDLE is accepted, so back-to-back frames with the minimum stop length are received.
- **Start-bit glitches:** any low pulse shorter than about 2 of the 3 sample points is rejected.
- **Ignored inputs:** `oafull` does not affect timing.

## Structure
- **Package `rs232_pkg`:**
  - parity mode constants `PARITY_NONE/ODD/EVEN`;
  - state enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - function `os_div(clock_freq, baud_rate)`.
- **Sub-module `rs232_os_tick`:** parametrised `OS_DIV` counter with synchronous `restart` input and `os_tick` output. It is reused by the planned 16x transmitter.

## Test plan
Bench uses `CLOCK_FREQ=7372800`, `BAUD_RATE=115200`, so `OS_DIV=4` and 64 clocks per bit.
1. 8N1, frame 0xA5 -> exactly one `oenable`; `odata=0xA5`; `operr=oferr=obreak=0`; strobe 1 clock after the stop-bit count-9 tick.
2. `PARITY=2`, 8E1, data 0x03 with parity bit 1 -> `odata=0x03`, `operr=1`, `oferr=0`. Then 0x03 with parity bit 0 -> `operr=0`.
3. 8N1, data 0x55 with stop bit 0, then line high -> `odata=0x55`, `oferr=1`, `obreak=0`. The next frame 0x0F is received clean.
4. Line held low for 20 bit times -> a single strobe with `odata=0`, `obreak=1`, `oferr=1`. No strobe until `rxd` rises; the following 0x3C is received correct.
5. Low glitch of 8 clocks (2 `os_tick`s) from idle -> no `oenable`, state back in IDLE. The following 0x81 is received correct.
6. Two cases:
   - `reset` pulsed for 1 clock during data bit 4 -> all outputs 0 and no strobe; the next 0xC3 frame is received correct.
   - `DATA_BITS=7`, `STOP_BITS=2`, 0x5A -> `odata=7'h5A`, single strobe.
   - Throughout: `rtsn_pin` tracks `oafull` in the same cycle.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receiver family: parity modes, receiver
// state encoding and the oversample divider calculation.
package rs232_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    // Clocks per 16x oversample tick, rounded to nearest.
    function automatic int os_div(input real clock_freq, input real baud_rate);
        return $rtoi(clock_freq / (16.0 * baud_rate) + 0.5);
    endfunction

endpackage

// File: rtl/rs232_os_tick.sv
// 16x oversample tick generator. Emits a one-clock os_tick every OS_DIV
// clocks; restart holds the phase at zero so the first tick after release
// arrives exactly OS_DIV clocks later.
module rs232_os_tick #(
    parameter int OS_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic os_tick
);

    localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OS_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Divider phase and registered tick pulse.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        tick_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Divider state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign os_tick = tick_q;

endmodule

// File: rtl/rs232_rx_framed.sv
// Parametrised RS232 receiver: configurable data width, optional parity,
// 1 or 2 stop bits, 16x oversampling with 3-sample majority vote, false
// start rejection and parity/framing/break reporting toward a push FIFO.
module rs232_rx_framed
    import rs232_pkg::*;
#(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd_pin,
    output logic                 rtsn_pin,
    output logic [DATA_BITS-1:0] odata,
    output logic                 operr,
    output logic                 oferr,
    output logic                 obreak,
    output logic                 oenable,
    input  logic                 oafull
);

    localparam int OS_DIV = os_div(CLOCK_FREQ, BAUD_RATE);
    localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);

    if (OS_DIV < 2) begin : g_bad_div
        $fatal(1, "rs232_rx_framed: clock too slow for 16x oversampling");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $fatal(1, "rs232_rx_framed: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "rs232_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $fatal(1, "rs232_rx_framed: PARITY must be 0, 1 or 2");
    end

    logic                 sync1_q, rxd;
    rx_state_t            state_q, state_d;
    logic [3:0]           samp_cnt_q, samp_cnt_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 stop0_q, stop0_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] odata_q, odata_d;
    logic                 operr_q, operr_d;
    logic                 oferr_q, oferr_d;
    logic                 obreak_q, obreak_d;
    logic                 oenable_q, oenable_d;

    logic os_tick, decide, voted, exp_par, last_stop, first_stop, brk;

    // Two-flop synchroniser on the asynchronous pin, idle-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxd     <= 1'b1;
        end else begin
            sync1_q <= rxd_pin;
            rxd     <= sync1_q;
        end
    end

    // Divider phase is pinned while idle so a new frame starts aligned.
    rs232_os_tick #(.OS_DIV(OS_DIV)) u_os_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (state_q == ST_IDLE),
        .os_tick (os_tick)
    );

    assign decide     = os_tick && (samp_cnt_q == 4'd9);
    assign voted      = (s7_q & s8_q) | (s7_q & rxd) | (s8_q & rxd);
    assign exp_par    = (PARITY == PARITY_ODD) ? ~(^shift_q) : (^shift_q);
    assign last_stop  = (STOP_BITS == 1) || stop_cnt_q;
    assign first_stop = stop_cnt_q ? stop0_q : voted;
    assign brk        = (shift_q == '0) && !par_bit_q && !first_stop;

    // Frame sequencing, bit voting and output capture.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        stop0_d    = stop0_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        odata_d    = odata_q;
        operr_d    = operr_q;
        oferr_d    = oferr_q;
        obreak_d   = obreak_q;
        oenable_d  = 1'b0;

        if (os_tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
            if (samp_cnt_q == 4'd7) s7_d = rxd;
            if (samp_cnt_q == 4'd8) s8_d = rxd;
        end

        case (state_q)
            ST_IDLE: begin
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                par_bit_d  = 1'b0;
                perr_d     = 1'b0;
                ferr_d     = 1'b0;
                if (!rxd) state_d = ST_START;
            end
            ST_START: begin
                // A start bit that votes high was a glitch.
                if (decide) state_d = voted ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shift_d   = {voted, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == BIT_LAST)
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_bit_d = voted;
                    perr_d    = (voted != exp_par);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (decide) begin
                    ferr_d     = ferr_q | ~voted;
                    stop0_d    = first_stop;
                    stop_cnt_d = 1'b1;
                    if (last_stop) begin
                        oenable_d = 1'b1;
                        odata_d   = shift_q;
                        operr_d   = perr_q;
                        oferr_d   = ferr_q | ~voted;
                        obreak_d  = brk;
                        state_d   = brk ? ST_BREAK_WAIT : ST_IDLE;
                    end
                end
            end
            ST_BREAK_WAIT: begin
                if (rxd) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            samp_cnt_q <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            stop0_q    <= 1'b1;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            odata_q    <= '0;
            operr_q    <= 1'b0;
            oferr_q    <= 1'b0;
            obreak_q   <= 1'b0;
            oenable_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            stop0_q    <= stop0_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            odata_q    <= odata_d;
            operr_q    <= operr_d;
            oferr_q    <= oferr_d;
            obreak_q   <= obreak_d;
            oenable_q  <= oenable_d;
        end
    end

    assign rtsn_pin = oafull;
    assign odata    = odata_q;
    assign operr    = operr_q;
    assign oferr    = oferr_q;
    assign obreak   = obreak_q;
    assign oenable  = oenable_q;

endmodule

// File: tb/tb_rs232_rx_framed.sv
// Bench for rs232_rx_framed: four receiver configurations (8N1, 8E1, 7N2,
// 9O1) driven with directed and random frames; expected results come from a
// frame-level model of the line protocol.
module tb_rs232_rx_framed;

    localparam real CF   = 7372800.0;
    localparam real BR   = 115200.0;
    localparam int  OSD  = $rtoi(CF / (16.0 * BR) + 0.5);
    localparam int  BIT  = 16 * OSD;

    int nb [4] = '{8, 8, 7, 9};
    int pm [4] = '{0, 2, 0, 1};
    int ns [4] = '{1, 1, 2, 1};

    typedef struct {
        int         sel;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
        longint     cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oafull = 1'b0;
    logic [3:0] rxd_v = 4'hF;
    logic [3:0] rtsn_v, pe_v, fe_v, bk_v, oen_v;
    logic [7:0] od0, od1;
    logic [6:0] od2;
    logic [8:0] od3;
    logic [8:0] odx [4];
    longint     cyc = 0;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign odx[0] = {1'b0, od0};
    assign odx[1] = {1'b0, od1};
    assign odx[2] = {2'b0, od2};
    assign odx[3] = od3;

    rs232_rx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clock(clk), .reset(reset), .rxd_pin(rxd_v[0]), .rtsn_pin(rtsn_v[0]), .odata(od0),
        .operr(pe_v[0]), .oferr(fe_v[0]), .obreak(bk_v[0]), .oenable(oen_v[0]), .oafull(oafull));
    rs232_rx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clock(clk), .reset(reset), .rxd_pin(rxd_v[1]), .rtsn_pin(rtsn_v[1]), .odata(od1),
        .operr(pe_v[1]), .oferr(fe_v[1]), .obreak(bk_v[1]), .oenable(oen_v[1]), .oafull(oafull));
    rs232_rx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_dut2 (
        .clock(clk), .reset(reset), .rxd_pin(rxd_v[2]), .rtsn_pin(rtsn_v[2]), .odata(od2),
        .operr(pe_v[2]), .oferr(fe_v[2]), .obreak(bk_v[2]), .oenable(oen_v[2]), .oafull(oafull));
    rs232_rx_framed #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u_dut3 (
        .clock(clk), .reset(reset), .rxd_pin(rxd_v[3]), .rtsn_pin(rtsn_v[3]), .odata(od3),
        .operr(pe_v[3]), .oferr(fe_v[3]), .obreak(bk_v[3]), .oenable(oen_v[3]), .oafull(oafull));

    // capture every push strobe, mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (oen_v[i]) begin
                obs_q.push_back('{sel: i, d: odx[i], pe: pe_v[i], fe: fe_v[i], bk: bk_v[i], cyc: cyc});
            end
        end
    end

    // random back-pressure, changed away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            #1 oafull = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one DUT pin for n clocks; entered and left at posedge+1
    task automatic hold(input int sel, input logic b, input int n);
        rxd_v[sel] = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // send one frame, record the model's expected result, then idle 2 bits
    task automatic send(input int sel, input logic [8:0] data, input bit par_flip,
                        input bit st0, input bit st1, output longint t0);
        int         mask;
        logic [8:0] d;
        logic       pbit;
        mask = (1 << nb[sel]) - 1;
        d    = 9'(data & mask);
        pbit = ((pm[sel] == 2) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0)) ^ par_flip;
        exp_q.push_back('{sel: sel, d: d,
                          pe: (pm[sel] != 0) && par_flip,
                          fe: !st0 || (ns[sel] == 2 && !st1),
                          bk: (d == 0) && (pm[sel] == 0 || !pbit) && !st0,
                          cyc: 0});
        t0 = cyc;
        hold(sel, 1'b0, BIT);
        for (int i = 0; i < nb[sel]; i++) hold(sel, d[i], BIT);
        if (pm[sel] != 0) hold(sel, pbit, BIT);
        hold(sel, st0, BIT);
        if (ns[sel] == 2) hold(sel, st1, BIT);
        hold(sel, 1'b1, 2 * BIT);
    endtask

    task automatic check_frames(input string tag);
        ev_t o, e;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_sel"},   64'(o.sel), 64'(e.sel));
            chk({tag, "_data"},  64'(o.d),   64'(e.d));
            chk({tag, "_perr"},  64'(o.pe),  64'(e.pe));
            chk({tag, "_ferr"},  64'(o.fe),  64'(e.fe));
            chk({tag, "_break"}, 64'(o.bk),  64'(e.bk));
        end
        obs_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) chk({tag, "_rtsn"}, 64'(rtsn_v[i]), 64'(oafull));
    endtask

    initial begin
        longint t0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_odata", {od3, od2, od1, od0}, 64'd0);
        chk("rst_flags", {pe_v, fe_v, bk_v, oen_v}, 64'd0);
        hold(0, 1'b1, 2 * BIT);

        // 8N1 0xA5 with latency check
        send(0, 9'hA5, 1'b0, 1'b1, 1'b1, t0);
        if (obs_q.size() > 0)
            chk("t1_latency", 64'(obs_q[0].cyc - t0), 64'(3 + OSD * (10 + 16 * 9) + 1));
        check_frames("t1");

        // 8E1 parity error then clean
        send(1, 9'h03, 1'b1, 1'b1, 1'b1, t0);
        send(1, 9'h03, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t2");

        // framing error then clean frame
        send(0, 9'h55, 1'b0, 1'b0, 1'b1, t0);
        send(0, 9'h0F, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t3");

        // break: 20 bit times low
        exp_q.push_back('{sel: 0, d: 9'h0, pe: 1'b0, fe: 1'b1, bk: 1'b1, cyc: 0});
        hold(0, 1'b0, 20 * BIT);
        hold(0, 1'b1, 2 * BIT);
        send(0, 9'h3C, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t4");

        // start glitch of 2 ticks
        hold(0, 1'b0, 2 * OSD);
        hold(0, 1'b1, 2 * BIT);
        check_frames("t5_glitch");
        send(0, 9'h81, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t5");

        // reset during data bit 4 of 0xC3
        hold(0, 1'b0, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b0, BIT);
        hold(0, 1'b0, BIT);
        hold(0, 1'b0, BIT / 2);
        reset = 1'b1;
        hold(0, 1'b1, 1);
        reset = 1'b0;
        chk("t6_rst_odata", {od3, od2, od1, od0}, 64'd0);
        chk("t6_rst_flags", {pe_v, fe_v, bk_v, oen_v}, 64'd0);
        hold(0, 1'b1, 3 * BIT);
        check_frames("t6_rst");
        send(0, 9'hC3, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t6a");

        // 7N2
        send(2, 9'h5A, 1'b0, 1'b1, 1'b1, t0);
        check_frames("t6b");

        // random frames on every configuration
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 6; k++) begin
                send(s, 9'($urandom), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0), t0);
            end
            check_frames("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
